// File: rtl/tt_um_my_processor.sv
// 8-bit accumulator CPU tile: 16-byte serially loaded program memory.
// Define DEMO_ROM_EN to preload a counter demo program on every reset.
module tt_um_my_processor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LDH  = 4'h2;
  localparam logic [3:0] OP_ADDI = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_MOV  = 4'h9;
  localparam logic [3:0] OP_LDR  = 4'hA;
  localparam logic [3:0] OP_IN   = 4'hB;
  localparam logic [3:0] OP_OUT  = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_JZ   = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  // the port keeps its harness name but is an active-high reset
  logic rst;
  assign rst = rst_n;

  logic [3:0] pc;
  logic [7:0] acc;
  logic [7:0] rf [4];
  logic       z_q;
  logic       c_q;
  logic       halt;
  logic [7:0] out_q;
  logic [7:0] mem [16];

  logic       prog;
  logic [3:0] prog_addr;
  assign prog      = uio_in[7];
  assign prog_addr = uio_in[3:0];

  logic       unused_pins;
  assign unused_pins = &{1'b0, ena, uio_in[6:4]};

  logic [7:0] instr;
  logic [3:0] op;
  logic [3:0] k;
  logic [1:0] r;
  logic [7:0] rv;
  assign instr = mem[pc];
  assign op    = instr[7:4];
  assign k     = instr[3:0];
  assign r     = k[1:0];
  assign rv    = rf[r];

  logic [7:0] addend;
  logic [8:0] sum;
  logic [8:0] diff;
  assign addend = (op == OP_ADDI) ? {4'h0, k} : rv;
  assign sum    = {1'b0, acc} + {1'b0, addend};
  assign diff   = {1'b0, acc} - {1'b0, rv};

  logic [7:0] acc_n;
  logic [3:0] pc_n;
  logic       c_n;
  logic       z_n;
  logic       z_upd;
  logic       halt_n;
  logic [7:0] out_n;
  logic       rf_we;

  always_comb begin
    acc_n  = acc;
    pc_n   = pc + 4'd1;
    c_n    = c_q;
    z_upd  = 1'b0;
    halt_n = halt;
    out_n  = out_q;
    rf_we  = 1'b0;
    unique case (op)
      OP_NOP: ;
      OP_LDI: begin
        acc_n = {4'h0, k};
        z_upd = 1'b1;
      end
      OP_LDH: begin
        acc_n = {k, acc[3:0]};
        z_upd = 1'b1;
      end
      OP_ADDI, OP_ADD: begin
        acc_n = sum[7:0];
        c_n   = sum[8];
        z_upd = 1'b1;
      end
      OP_SUB: begin
        acc_n = diff[7:0];
        c_n   = diff[8];
        z_upd = 1'b1;
      end
      OP_AND: begin
        acc_n = acc & rv;
        z_upd = 1'b1;
      end
      OP_OR: begin
        acc_n = acc | rv;
        z_upd = 1'b1;
      end
      OP_XOR: begin
        acc_n = acc ^ rv;
        z_upd = 1'b1;
      end
      OP_MOV: rf_we = 1'b1;
      OP_LDR: begin
        acc_n = rv;
        z_upd = 1'b1;
      end
      OP_IN: begin
        acc_n = ui_in;
        z_upd = 1'b1;
      end
      OP_OUT: out_n = acc;
      OP_JMP: pc_n = k;
      OP_JZ:  pc_n = z_q ? k : pc + 4'd1;
      OP_HLT: halt_n = 1'b1;
      default: ;
    endcase
    z_n = z_upd ? (acc_n == 8'h00) : z_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= 4'h0;
      acc   <= 8'h00;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      halt  <= 1'b0;
      out_q <= 8'h00;
      for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
    end else if (prog) begin
      pc   <= 4'h0;
      halt <= 1'b0;
    end else if (!halt) begin
      pc    <= pc_n;
      acc   <= acc_n;
      z_q   <= z_n;
      c_q   <= c_n;
      halt  <= halt_n;
      out_q <= out_n;
      if (rf_we) rf[r] <= acc;
    end
  end

  // program memory is never cleared; only the demo build preloads it
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef DEMO_ROM_EN
      for (int i = 0; i < 16; i++) mem[i] <= 8'hF0;
      mem[0] <= 8'h10;
      mem[1] <= 8'hC0;
      mem[2] <= 8'h31;
      mem[3] <= 8'hD1;
`else
      ;
`endif
    end else if (prog) begin
      mem[prog_addr] <= ui_in;
    end
  end

  assign uo_out  = out_q;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_my_processor.sv
// Directed bench for tt_um_my_processor with an expected-output scoreboard.
// Optional DEMO_ROM_EN section follows the RTL macro.
module tb_tt_um_my_processor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q [$];
  logic [7:0] prg [16];
  int         prg_n;

  tt_um_my_processor dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic sb_push(input logic [7:0] v);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input string tag);
    logic [7:0] want;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s observed=%h expected=<empty scoreboard>", tag, uo_out);
    end else begin
      want = exp_q.pop_front();
      chk(tag, uo_out, want);
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < prg_n; i++) begin
      uio_in = {1'b1, 3'b000, 4'(i)};
      ui_in  = prg[i];
      tick();
    end
    uio_in = 8'h00;
  endtask

  initial begin
    ena    = 1'b1;
    rst_n  = 1'b1;
    ui_in  = 8'($urandom);
    uio_in = 8'($urandom);
    tick();
    ui_in  = 8'($urandom);
    uio_in = 8'($urandom);
    tick();
    sb_push(8'h00);
    sb_check("reset_uo_out");
    chk("reset_uio_out", uio_out, 8'h00);
    chk("reset_uio_oe", uio_oe, 8'h00);

`ifdef DEMO_ROM_EN
    uio_in = 8'h00;
    ui_in  = 8'h00;
    rst_n  = 1'b0;
    tick(2);
    sb_push(8'h00);
    sb_check("demo_edge2");
    tick(3);
    sb_push(8'h01);
    sb_check("demo_edge5");
    tick(3);
    sb_push(8'h02);
    sb_check("demo_edge8");
    tick(3 * 254);
    sb_push(8'h00);
    sb_check("demo_wrap");
    rst_n = 1'b1;
    tick();
`endif

    // enter PROG while still in reset so nothing runs from empty memory
    uio_in = 8'h80;
    tick();
    rst_n = 1'b0;

    // IN, MOV 0, LDI 5, SUB 0, OUT, HLT
    prg[0] = 8'hB0; prg[1] = 8'h90; prg[2] = 8'h15;
    prg[3] = 8'h50; prg[4] = 8'hC0; prg[5] = 8'hF0;
    prg_n  = 6;
    load_prog();
    ui_in = 8'h07;
    tick(6);
    sb_push(8'hFE);
    sb_check("sub_borrow_out");
    chk("sub_borrow_c", {7'b0, dut.c_q}, 8'h01);
    ui_in = 8'h55;
    tick(4);
    sb_push(8'hFE);
    sb_check("sub_halt_frozen");

    // LDI F, LDH F, ADDI 1, OUT, HLT
    prg[0] = 8'h1F; prg[1] = 8'h2F; prg[2] = 8'h31;
    prg[3] = 8'hC0; prg[4] = 8'hF0;
    prg_n  = 5;
    load_prog();
    tick(2);
    chk("ldh_acc", dut.acc, 8'hFF);
    tick(3);
    sb_push(8'h00);
    sb_check("wrap_out");
    chk("wrap_acc", dut.acc, 8'h00);
    chk("wrap_c", {7'b0, dut.c_q}, 8'h01);
    chk("wrap_z", {7'b0, dut.z_q}, 8'h01);
    tick(3);
    sb_push(8'h00);
    sb_check("wrap_frozen");
    chk("wrap_acc_frozen", dut.acc, 8'h00);

    // LDI A, LDH A, OUT, LDI 0, JZ 6, OUT, OUT, HLT
    prg[0] = 8'h1A; prg[1] = 8'h2A; prg[2] = 8'hC0; prg[3] = 8'h10;
    prg[4] = 8'hE6; prg[5] = 8'hC0; prg[6] = 8'hC0; prg[7] = 8'hF0;
    prg_n  = 8;
    load_prog();
    tick(3);
    sb_push(8'hAA);
    sb_check("jz_prior_aa");
    tick(2);
    sb_push(8'hAA);
    sb_check("jz_no_early_out");
    chk("jz_taken_pc", {4'h0, dut.pc}, 8'h06);
    tick();
    sb_push(8'h00);
    sb_check("jz_one_out");

    // LDI 3, JZ 5 (not taken), OUT, HLT
    prg[0] = 8'h13; prg[1] = 8'hE5; prg[2] = 8'hC0; prg[3] = 8'hF0;
    prg_n  = 4;
    load_prog();
    tick(3);
    sb_push(8'h03);
    sb_check("jz_not_taken");
    tick(2);

    // PROG while halted: rewrite address 0 with LDI 7 and restart
    uio_in = 8'h80;
    ui_in  = 8'h17;
    tick();
    chk("prog_pc_zero", {4'h0, dut.pc}, 8'h00);
    chk("prog_halt_clr", {7'b0, dut.halt}, 8'h00);
    uio_in = 8'h00;
    tick(3);
    sb_push(8'h07);
    sb_check("restart_out");

    // ADDI 1, OUT, JMP 0 loop, then reset mid-loop
    prg[0] = 8'h31; prg[1] = 8'hC0; prg[2] = 8'hD0;
    prg_n  = 3;
    load_prog();
    tick(5);
    sb_push(8'h09);
    sb_check("loop_count");
    rst_n = 1'b1;
    tick();
    sb_push(8'h00);
    sb_check("midloop_reset");
    chk("midloop_reset_acc", dut.acc, 8'h00);
    rst_n = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tt_um_my_processor.md
# tt_um_my_processor

Minimal 8-bit accumulator CPU packaged as a Tiny Tapeout user tile. It executes one instruction per clock from a 16-byte on-chip program memory, which is loaded serially through the tile pins. It holds an accumulator, four general registers, and Z/C flags, and presents results on the dedicated output pins. The block is the top level of the tile and sits directly under the Tiny Tapeout harness.

## Interface
No parameters.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-high. The port keeps the harness name, but the asserted level is 1; sampled on the rising `clk` edge.
- `ena`  in  1  tile enable from the harness; ignored.
- `ui_in`  in  8  data for `IN` in run mode; program byte in PROG mode.
- `uio_in`  in  8  bit 7 = PROG (1 = programming mode); bits 3:0 = program write address; bits 6:4 unused.
- `uo_out`  out  8  output register, written by `OUT`.
- `uio_out`  out  8  constant 8'h00.
- `uio_oe`  out  8  constant 8'h00; all uio pins are inputs.

## Operation
- State:
  - PC: 4 bits.
  - ACC: 8 bits.
  - R0..R3: 8 bits each.
  - Flags Z and C.
  - HALT flag.
  - OUT register.
  - MEM: 16×8 program memory.
- Instruction format: opcode [7:4], operand k [3:0]. Register index r = k[1:0].
- Opcodes:
  - 0 NOP.
  - 1 LDI: ACC = {4'h0,k}.
  - 2 LDH: ACC[7:4] = k.
  - 3 ADDI: ACC = ACC + k (k zero-extended).
  - 4 ADD: ACC = ACC + Rr.
  - 5 SUB: ACC = ACC − Rr.
  - 6 AND: ACC = ACC & Rr.
  - 7 OR: ACC = ACC | Rr.
  - 8 XOR: ACC = ACC ^ Rr.
  - 9 MOV: Rr = ACC.
  - A LDR: ACC = Rr.
  - B IN: ACC = `ui_in`.
  - C OUT: OUT = ACC.
  - D JMP: PC = k.
  - E JZ: PC = k if Z = 1, else PC + 1.
  - F HLT: set HALT.
- Arithmetic is 8-bit, modulo 256.
  - C = carry out for ADDI and ADD.
  - C = borrow for SUB (1 when ACC < Rr).
  - Other instructions leave C unchanged.
- Z = (new ACC == 0). It is updated by opcodes 1–8, A and B only.
- PC increments by 1 after every non-jump instruction and wraps from 15 to 0.
- HALT: PC and all state are frozen, and no instruction executes. HALT is left only by reset or by PROG mode.
- PROG mode (`uio_in[7]` = 1), applied every cycle:
  - MEM[`uio_in[3:0]`] = `ui_in`.
  - PC = 0, HALT = 0.
  - No instruction executes.
  - ACC, registers, flags and OUT are retained.
- Run resumes at address 0 in the first cycle after PROG returns to 0.
- Reset: PC, ACC, R0–R3, Z, C, HALT and OUT are cleared to 0, so `uo_out` = 8'h00. Reset overrides PROG; no MEM write occurs in a reset cycle.
- Reset asserted mid-instruction or mid-program: the state above is cleared at the next edge. MEM is handled as described under Configuration.

## Timing
- Single-cycle execution. The instruction at MEM[PC] is read combinationally and all results commit on the next rising edge.
- `uo_out` is registered. An `OUT` executed in cycle n is visible on `uo_out` after edge n.
- `IN` samples `ui_in` at the executing edge.
- The first instruction (address 0) executes on the first edge with reset deasserted.
- A PROG write is effective at the edge. The byte is readable the following cycle.
- If PROG and a `HLT` fetch fall in the same cycle, PROG wins.

## Configuration
- `DEMO_ROM_EN` defined: every reset cycle also loads MEM with the demo program:
  - Addresses 0..3: 8'h10 (LDI 0), 8'hC0 (OUT), 8'h31 (ADDI 1), 8'hD1 (JMP 1).
  - Addresses 4..15: 8'hF0 (HLT).
  - Result: `uo_out` counts 0,1,2,… with a new value every 3 cycles and wraps 8'hFF→8'h00.
- `DEMO_ROM_EN` not defined: reset does not touch MEM. MEM holds only what PROG mode wrote; unwritten locations are undefined.

## Test plan
- Reset held (`rst_n`=1) for 2 edges with random inputs → `uo_out` = 8'h00, `uio_out` = 8'h00, `uio_oe` = 8'h00.
- `DEMO_ROM_EN` defined, reset released → `uo_out` = 0 after edge 2, 1 after edge 5, 2 after edge 8. After 256 increments it reads 8'h00 again.
- PROG load of 8'h1F, 8'h2F, 8'h31, 8'hC0, 8'hF0 (LDI F, LDH F, ADDI 1, OUT, HLT), then run → ACC wraps to 8'h00 with C = 1 and Z = 1. `uo_out` = 8'h00 and stays frozen after HLT.
- Program IN, MOV 0, LDI 5, SUB 0, OUT, HLT with `ui_in` = 8'h07 → `uo_out` = 8'hFE, C = 1.
- Program LDI 0, JZ 3, OUT, OUT, HLT after a prior `uo_out` of 8'hAA → the branch is taken, and exactly one OUT writes 8'h00.
- PROG asserted during HLT → PC = 0. Execution restarts at address 0 after PROG drops. Reset asserted mid-loop → `uo_out` = 8'h00 on the next edge.
